program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Upstream stage of the accumulator CPU: receives a byte stream over a valid/ready handshake and assembles it into 16-bit instructions. It writes those instructions into program memory through a write port, one word per accepted byte pair.
While a load is in progress it holds the CPU core in reset. It releases the core only after a checksum-verified image has been written.
The block sits between the host/serial front end and program_memory / the program_counter reset input.

Parameters:
INSTR_WIDTH, 16, instruction word width; must equal 2*BYTE_WIDTH.
ADDR_WIDTH, 5, program memory address width; capacity 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, width of the input stream symbol.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
load_req  input  1  one-cycle pulse that starts a load; honoured only in IDLE, DONE or ERR.
in_valid  input  1  stream byte valid.
in_data  input  BYTE_WIDTH  stream byte.
in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
pm_we  output  1  program memory write enable, one-cycle pulse.
pm_addr  output  ADDR_WIDTH  program memory write address.
pm_wdata  output  INSTR_WIDTH  program memory write data.
cpu_hold  output  1  active-high reset request to the core (program_counter and datapath).
done  output  1  level; image loaded and verified.
error  output  1  level; bad length or checksum.

Behaviour:
- Reset (rst=0, asynchronous) forces the following:
  - state=IDLE; all outputs 0 except cpu_hold=1; internal count, address and checksum registers 0.
- Image format, in byte order:
  - LEN: N, the instruction count.
  - N pairs of bytes, high byte first, then low byte.
  - CHK: XOR of all 2N payload bytes. LEN is excluded from the checksum.
- States: IDLE, LEN, HI, LO, CHK, DONE, ERR.
- in_ready is a function of state only: 1 in LEN/HI/LO/CHK, 0 in IDLE/DONE/ERR.
  - It does not depend combinationally on in_valid.
- IDLE: cpu_hold=1. load_req -> LEN; clear addr, count and checksum.
- LEN on a transfer:
  - if N==0 or N>2**ADDR_WIDTH -> ERR;
  - otherwise latch N and go to HI.
- HI on a transfer: latch the byte into the upper half; xor it into the checksum; go to LO.
- LO on a transfer, same cycle:
  - xor the byte into the checksum;
  - register a write: next cycle pm_we=1, pm_addr=addr, pm_wdata={hi,byte};
  - addr increments after the write.
  - If this was word N -> CHK, else -> HI.
- Write latency: exactly 1 cycle after the LO transfer. pm_addr and pm_wdata hold their value until the next write.
- CHK on a transfer:
  - byte == checksum -> DONE;
  - otherwise -> ERR.
- DONE: done=1, cpu_hold=0; the core runs from address 0.
- ERR: error=1, cpu_hold=1. Program memory contents are undefined.
- load_req in DONE or ERR -> LEN; clears done/error and reasserts cpu_hold in the same edge.
- load_req in LEN/HI/LO/CHK is ignored; there is no restart mid-load.
- Stalls: in_valid low in any receive state holds the state indefinitely. There is no timeout.
- Address wrap: when N==2**ADDR_WIDTH, addr wraps to 0 after the last write. It is never used again in that load.
- Reset mid-load aborts immediately: IDLE, pm_we=0 on the same asynchronous assertion, cpu_hold=1.
- cpu_hold is registered and glitch-free.

Decomposition:
- Package program_loader_pkg:
  - state enum loader_state_t {IDLE, LEN, HI, LO, CHK, DONE, ERR};
  - default width localparams;
  - function max_words(ADDR_WIDTH).
- Natural sub-module: loader_checksum, an XOR accumulator with clear/enable and a compare output. It is reusable by a later data-memory loader.
- Everything else lives in one always_ff FSM plus output registers.

Test Plan:
- Nominal load:
  - stimulus: load_req, then bytes 02, 12,34, AB,CD, checksum 12^34^AB^CD=40, with in_valid continuous;
  - required: pm_we pulses with (0,1234) and (1,ABCD), each one cycle after its low byte;
  - required: done=1, cpu_hold=0, error=0.
- Bad checksum:
  - stimulus: same image with checksum 41;
  - required: both writes still occur; error=1, done=0, cpu_hold stays 1; in_ready=0 afterwards.
- Length bounds:
  - stimulus: LEN=00, and separately LEN=21 (33 words with ADDR_WIDTH=5);
  - required: ERR straight after the header; no pm_we.
  - stimulus: LEN=20;
  - required: 32 writes at addresses 0..31 and done=1.
- Handshake stalls:
  - stimulus: random in_valid gaps, plus load_req pulsed mid-load;
  - required: the same writes and result as the nominal case; load_req has no effect while busy.
- Reset mid-load:
  - stimulus: rst=0 asynchronously between HI and LO of word 1;
  - required: immediately pm_we=0, cpu_hold=1, done=error=0;
  - required: after release the FSM is in IDLE with in_ready=0, and a new load succeeds.
- Reload:
  - stimulus: load_req issued in DONE, and again in ERR;
  - required: next cycle done/error=0, cpu_hold=1, in_ready=1, and the addresses restart at 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and sizing helpers for the program loader.
// Provides the loader state enum, default widths and max_words().
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      CHK,
      DONE,
      ERR
   } loader_state_t;

   localparam int DEF_INSTR_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH  = 5;
   localparam int DEF_BYTE_WIDTH  = 8;

   function automatic int max_words(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// XOR accumulator with synchronous clear/enable and a compare output.
// Ports: clk, rst (async low), clr, en, din, cmp -> match.
module loader_checksum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] cmp,
   output logic             match
);

   logic [WIDTH-1:0] sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum ^ din;
      end
   end

   assign match = (sum == cmp);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: LEN, N hi/lo pairs, XOR checksum.
// Ports: clk, rst, load_req, in_valid/in_data/in_ready,
//   pm_we/pm_addr/pm_wdata, cpu_hold, done, error.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int BYTE_WIDTH  = DEF_BYTE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_req,
   input  logic                   in_valid,
   input  logic [BYTE_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   output logic                   pm_we,
   output logic [ADDR_WIDTH-1:0]  pm_addr,
   output logic [INSTR_WIDTH-1:0] pm_wdata,
   output logic                   cpu_hold,
   output logic                   done,
   output logic                   error
);

   // One extra bit so a full memory (2**ADDR_WIDTH words) is countable.
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [31:0] MAXW = 32'(max_words(ADDR_WIDTH));

   loader_state_t state, state_next;

   logic [CW-1:0]         n_words;
   logic [CW-1:0]         wcnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic [BYTE_WIDTH-1:0] hi_byte;

   logic xfer;
   logic start;
   logic len_take;
   logic hi_take;
   logic lo_take;
   logic len_ok;
   logic last_word;
   logic sum_match;

   assign in_ready = (state == LEN) || (state == HI) ||
                     (state == LO)  || (state == CHK);
   assign xfer     = in_valid && in_ready;

   assign len_ok    = (in_data != '0) && (32'(in_data) <= MAXW);
   assign last_word = ((wcnt + CW'(1)) == n_words);

   always_comb begin
      state_next = state;
      start      = 1'b0;
      len_take   = 1'b0;
      hi_take    = 1'b0;
      lo_take    = 1'b0;
      unique case (state)
         IDLE, DONE, ERR: begin
            if (load_req) begin
               state_next = LEN;
               start      = 1'b1;
            end
         end
         LEN: begin
            if (xfer) begin
               if (len_ok) begin
                  state_next = HI;
                  len_take   = 1'b1;
               end else begin
                  state_next = ERR;
               end
            end
         end
         HI: begin
            if (xfer) begin
               state_next = LO;
               hi_take    = 1'b1;
            end
         end
         LO: begin
            if (xfer) begin
               lo_take    = 1'b1;
               state_next = last_word ? CHK : HI;
            end
         end
         CHK: begin
            if (xfer) begin
               state_next = sum_match ? DONE : ERR;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   loader_checksum #(
      .WIDTH (BYTE_WIDTH)
   ) u_checksum (
      .clk   (clk),
      .rst   (rst),
      .clr   (start),
      .en    (hi_take || lo_take),
      .din   (in_data),
      .cmp   (in_data),
      .match (sum_match)
   );

   // Status outputs follow the next state so they switch on the same
   // edge as the FSM and stay glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         n_words  <= '0;
         wcnt     <= '0;
         addr     <= '0;
         hi_byte  <= '0;
         pm_we    <= 1'b0;
         pm_addr  <= '0;
         pm_wdata <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state    <= state_next;
         pm_we    <= lo_take;
         cpu_hold <= (state_next != DONE);
         done     <= (state_next == DONE);
         error    <= (state_next == ERR);
         if (start) begin
            n_words <= '0;
            wcnt    <= '0;
            addr    <= '0;
         end
         if (len_take) begin
            n_words <= CW'(in_data);
         end
         if (hi_take) begin
            hi_byte <= in_data;
         end
         if (lo_take) begin
            pm_addr  <= addr;
            pm_wdata <= INSTR_WIDTH'({hi_byte, in_data});
            addr     <= addr + ADDR_WIDTH'(1);
            wcnt     <= wcnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of load scenarios plus
// hand-written full-memory, stall and mid-load reset sequences.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_req = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        pm_we;
   logic [4:0]  pm_addr;
   logic [15:0] pm_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   program_loader dut (
      .clk      (clk),
      .rst      (rst),
      .load_req (load_req),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .pm_we    (pm_we),
      .pm_addr  (pm_addr),
      .pm_wdata (pm_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   always @(negedge clk) begin
      if (pm_we) wr_count++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      tag;
      logic [7:0] len;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0] ck;
      int         nsend;
      int         gap;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] words[32];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap,
                            input bit poke);
      int k;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         load_req = poke && (g == 0);
         @(posedge clk);
         #1;
         load_req = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!in_ready) begin
         check("ready_timeout", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic start_load(input string tag);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check({tag, "_start_ready"}, {31'b0, in_ready}, 32'd1);
      check({tag, "_start_hold"},  {31'b0, cpu_hold}, 32'd1);
      check({tag, "_start_done"},  {31'b0, done}, 32'd0);
      check({tag, "_start_err"},   {31'b0, error}, 32'd0);
   endtask

   task automatic run_load(input string tag, input logic [7:0] len,
                           input int nsend, input logic [7:0] ck,
                           input int gapmax, input bit exp_done,
                           input bit exp_err);
      int w0;
      int g;
      w0 = wr_count;
      start_load(tag);
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      send_byte(len, g, gapmax > 0);
      for (int i = 0; i < nsend; i++) begin
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         send_byte(words[i][15:8], g, gapmax > 0);
         check({tag, "_we_after_hi"}, {31'b0, pm_we}, 32'd0);
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         send_byte(words[i][7:0], g, gapmax > 0);
         check({tag, "_we"},    {31'b0, pm_we}, 32'd1);
         check({tag, "_addr"},  {27'b0, pm_addr}, 32'(i));
         check({tag, "_wdata"}, {16'b0, pm_wdata}, {16'b0, words[i]});
      end
      if (nsend > 0) begin
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         send_byte(ck, g, gapmax > 0);
      end
      check({tag, "_done"},  {31'b0, done}, {31'b0, exp_done});
      check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
      check({tag, "_hold"},  {31'b0, cpu_hold}, {31'b0, !exp_done});
      check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_nwrites"}, 32'(wr_count - w0), 32'(nsend));
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_we"},    {31'b0, pm_we}, 32'd0);
      check({tag, "_hold"},  {31'b0, cpu_hold}, 32'd1);
      check({tag, "_done"},  {31'b0, done}, 32'd0);
      check({tag, "_err"},   {31'b0, error}, 32'd0);
      check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
   endtask

   task automatic release_and_idle(input string tag);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_idle_hold"},  {31'b0, cpu_hold}, 32'd1);
   endtask

   initial begin
      logic [7:0] ck32;

      vecs[0] = '{"nominal", 8'h02, 16'h1234, 16'hABCD, 8'h40, 2, 0, 1'b1, 1'b0};
      vecs[1] = '{"badchk",  8'h02, 16'h1234, 16'hABCD, 8'h41, 2, 0, 1'b0, 1'b1};
      vecs[2] = '{"len0",    8'h00, 16'h0000, 16'h0000, 8'h00, 0, 0, 1'b0, 1'b1};
      vecs[3] = '{"reload",  8'h02, 16'h1234, 16'hABCD, 8'h40, 2, 0, 1'b1, 1'b0};
      vecs[4] = '{"len33",   8'h21, 16'h0000, 16'h0000, 8'h00, 0, 0, 1'b0, 1'b1};
      vecs[5] = '{"stall",   8'h02, 16'h1234, 16'hABCD, 8'h40, 2, 3, 1'b1, 1'b0};

      #2 rst = 1'b0;
      #20;
      reset_checks("reset");
      check("reset_addr",  {27'b0, pm_addr}, 32'd0);
      check("reset_wdata", {16'b0, pm_wdata}, 32'd0);
      release_and_idle("reset");

      for (int v = 0; v < 6; v++) begin
         words[0] = vecs[v].w0;
         words[1] = vecs[v].w1;
         run_load(vecs[v].tag, vecs[v].len, vecs[v].nsend, vecs[v].ck,
                  vecs[v].gap, vecs[v].exp_done, vecs[v].exp_err);
      end

      ck32 = 8'h00;
      for (int i = 0; i < 32; i++) begin
         words[i][15:8] = 8'(i * 3);
         words[i][7:0]  = 8'hC0 ^ 8'(i);
         ck32 = ck32 ^ words[i][15:8] ^ words[i][7:0];
      end
      run_load("len32", 8'h20, 32, ck32, 0, 1'b1, 1'b0);

      words[0] = 16'h1234;
      words[1] = 16'hABCD;

      start_load("rstwe");
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      send_byte(8'h34, 0, 1'b0);
      check("rstwe_pre_we", {31'b0, pm_we}, 32'd1);
      #1 rst = 1'b0;
      #1;
      reset_checks("rstwe");
      release_and_idle("rstwe");

      start_load("rstmid");
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      send_byte(8'h34, 0, 1'b0);
      send_byte(8'hAB, 0, 1'b0);
      #2 rst = 1'b0;
      #1;
      reset_checks("rstmid");
      release_and_idle("rstmid");

      run_load("after_rst", 8'h02, 2, 8'h40, 0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
